timer_bank: RTL and testbench

TIMER_BANK -- requirements
Module: timer_bank

---
 rtl/timer_bank_if.sv | 48 ++++
 rtl/timer_bank.sv | 239 +++++++++++++++++++++++
 tb/tb_timer_bank.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_bank_if.sv
`default_nettype none
// ============================================================================
//  Module      : timer_bank_if
//  Description : Request/response bus bundle for the timer bank register
//                file. One request is presented with i_VALID; the slave
//                answers with a single-cycle o_READY strobe carrying o_rdata.
//                Member names are from the slave's point of view.
//                  i_VALID  - request valid
//                  i_addr   - byte address ([7:4] channel, [3:2] register)
//                  i_wren   - 1 = write, 0 = read
//                  i_wdata  - store data
//                  i_strb   - byte strobes for writes
//                  o_READY  - response strobe
//                  o_rdata  - read data, zero unless o_READY is high
//  Revision    : 1.0 - initial release
// ============================================================================
interface timer_bank_if;

    logic        i_VALID;
    logic [7:0]  i_addr;
    logic        i_wren;
    logic [31:0] i_wdata;
    logic [3:0]  i_strb;
    logic        o_READY;
    logic [31:0] o_rdata;

    modport master (
        output i_VALID,
        output i_addr,
        output i_wren,
        output i_wdata,
        output i_strb,
        input  o_READY,
        input  o_rdata
    );

    modport slave (
        input  i_VALID,
        input  i_addr,
        input  i_wren,
        input  i_wdata,
        input  i_strb,
        output o_READY,
        output o_rdata
    );

endinterface
`default_nettype wire

// File: rtl/timer_bank.sv
`default_nettype none
// ============================================================================
//  Module      : timer_bank
//  Description : Bank of N_CH independent prescaled up-counters with compare
//                match, overflow detection and per-channel level interrupts,
//                accessed through a two-cycle request/response register bus.
//  Ports       : i_clk    - sole clock, rising edge
//                i_rst_n  - asynchronous active-low reset
//                bus      - timer_bank_if.slave register bus
//                o_irq    - per-channel interrupt, IE & (MATCH | OVF)
//  Registers   : per channel at [7:4]=channel, [3:2]=register
//                0x0 CTRL    : [0] EN, [1] RELOAD, [2] IE, [8+:PRE_W] PRESC
//                0x4 COUNT   : CNT_W bits, zero-extended on read
//                0x8 COMPARE : CNT_W bits, resets to all-ones
//                0xC STATUS  : [0] MATCH, [1] OVF, sticky, write-1-to-clear
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_bank #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 32,
    parameter int PRE_W = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    timer_bank_if.slave     bus,
    output logic [N_CH-1:0] o_irq
);

    // ------------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_accept;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.i_VALID) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                // requests presented here are not seen; master must hold
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Address decode and byte mask
    // ------------------------------------------------------------------------
    logic [3:0]  w_ch;
    logic [1:0]  w_reg;
    logic [31:0] w_mask;
    logic        w_wr;

    assign w_ch   = bus.i_addr[7:4];
    assign w_reg  = bus.i_addr[3:2];
    assign w_mask = {{8{bus.i_strb[3]}}, {8{bus.i_strb[2]}},
                     {8{bus.i_strb[1]}}, {8{bus.i_strb[0]}}};
    assign w_wr   = w_accept & bus.i_wren;

    // Address bits [1:0] are ignored, and parts of the data/mask above the
    // implemented field widths have no destination.
    logic w_unused;
    assign w_unused = ^{bus.i_addr[1:0], bus.i_wdata, w_mask};

    // Per-channel read value for the currently addressed register
    logic [N_CH-1:0][31:0] w_rd_ch;

    // ------------------------------------------------------------------------
    // Timer channels
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        localparam logic [3:0] c_IDX = 4'(gi);

        logic             r_en;
        logic             r_reload;
        logic             r_ie;
        logic [PRE_W-1:0] r_presc;
        logic [PRE_W-1:0] r_pre;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] r_cmp;
        logic             r_match;
        logic             r_ovf;

        logic             w_sel;
        logic             w_wr_ctrl;
        logic             w_wr_cnt;
        logic             w_wr_cmp;
        logic             w_wr_sts;
        logic             w_tick;
        logic             w_hit_cmp;
        logic             w_hit_max;
        logic             w_set_match;
        logic             w_set_ovf;
        logic             w_clr_match;
        logic             w_clr_ovf;
        logic [CNT_W-1:0] w_cnt_mrg;
        logic [CNT_W-1:0] w_cmp_mrg;
        logic [PRE_W-1:0] w_presc_mrg;
        logic [31:0]      w_rd;

        // Channel numbers that have no g_ch instance never match, so writes
        // to unmapped channels fall away here.
        assign w_sel     = w_wr && (w_ch == c_IDX);
        assign w_wr_ctrl = w_sel && (w_reg == 2'd0);
        assign w_wr_cnt  = w_sel && (w_reg == 2'd1);
        assign w_wr_cmp  = w_sel && (w_reg == 2'd2);
        assign w_wr_sts  = w_sel && (w_reg == 2'd3);

        assign w_tick    = r_en && (r_pre == r_presc);
        assign w_hit_cmp = (r_cnt == r_cmp);
        assign w_hit_max = &r_cnt;

        // A COUNT write replaces the tick outcome entirely, flags included
        assign w_set_match = w_tick & w_hit_cmp & ~w_wr_cnt;
        assign w_set_ovf   = w_tick & w_hit_max & ~w_wr_cnt;
        assign w_clr_match = w_wr_sts & bus.i_strb[0] & bus.i_wdata[0];
        assign w_clr_ovf   = w_wr_sts & bus.i_strb[0] & bus.i_wdata[1];

        assign w_cnt_mrg   = (r_cnt & ~w_mask[CNT_W-1:0]) |
                             (bus.i_wdata[CNT_W-1:0] & w_mask[CNT_W-1:0]);
        assign w_cmp_mrg   = (r_cmp & ~w_mask[CNT_W-1:0]) |
                             (bus.i_wdata[CNT_W-1:0] & w_mask[CNT_W-1:0]);
        assign w_presc_mrg = (r_presc & ~w_mask[8 +: PRE_W]) |
                             (bus.i_wdata[8 +: PRE_W] & w_mask[8 +: PRE_W]);

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_en     <= 1'b0;
                r_reload <= 1'b0;
                r_ie     <= 1'b0;
                r_presc  <= '0;
                r_pre    <= '0;
                r_cnt    <= '0;
                r_cmp    <= '1;
                r_match  <= 1'b0;
                r_ovf    <= 1'b0;
            end else begin
                // Prescaler restarts on any reconfiguration of the channel
                if (w_wr_ctrl || w_wr_cnt) begin
                    r_pre <= '0;
                end else if (r_en) begin
                    r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);
                end

                if (w_wr_ctrl) begin
                    r_en     <= (r_en     & ~w_mask[0]) | (bus.i_wdata[0] & w_mask[0]);
                    r_reload <= (r_reload & ~w_mask[1]) | (bus.i_wdata[1] & w_mask[1]);
                    r_ie     <= (r_ie     & ~w_mask[2]) | (bus.i_wdata[2] & w_mask[2]);
                    r_presc  <= w_presc_mrg;
                end

                // Match-with-reload and plain increment both wrap all-ones to 0
                if (w_wr_cnt) begin
                    r_cnt <= w_cnt_mrg;
                end else if (w_tick) begin
                    r_cnt <= (w_hit_cmp && r_reload) ? '0 : r_cnt + CNT_W'(1);
                end

                if (w_wr_cmp) begin
                    r_cmp <= w_cmp_mrg;
                end

                // Hardware set takes priority over a simultaneous clear
                r_match <= (r_match & ~w_clr_match) | w_set_match;
                r_ovf   <= (r_ovf   & ~w_clr_ovf)   | w_set_ovf;
            end
        end

        assign o_irq[gi] = r_ie & (r_match | r_ovf);

        always_comb begin
            w_rd = '0;
            case (w_reg)
                2'd0:    w_rd = 32'({r_presc, 5'b0, r_ie, r_reload, r_en});
                2'd1:    w_rd = 32'(r_cnt);
                2'd2:    w_rd = 32'(r_cmp);
                2'd3:    w_rd = {30'b0, r_ovf, r_match};
                default: w_rd = '0;
            endcase
        end

        assign w_rd_ch[gi] = w_rd;
    end

    // ------------------------------------------------------------------------
    // Read mux and response register
    // ------------------------------------------------------------------------
    logic [31:0] w_rd_sel;
    logic [31:0] r_rdata;

    // Unmapped channel numbers leave the default of zero in place
    always_comb begin
        w_rd_sel = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (w_ch == 4'(k)) begin
                w_rd_sel = w_rd_ch[k];
            end
        end
    end

    // Data is captured at acceptance (pre-write, pre-tick values). Writes
    // answer with zero, and the register is cleared leaving RESP so that
    // o_rdata is zero whenever o_READY is low.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (w_accept && !bus.i_wren) begin
            r_rdata <= w_rd_sel;
        end else begin
            r_rdata <= '0;
        end
    end

    assign bus.o_READY = (r_state == S_RESP);
    assign bus.o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_timer_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_bank
//  Description : Directed bench for timer_bank (N_CH=4, CNT_W=8, PRE_W=8).
//                A behavioural register/timer model runs alongside the DUT
//                and a compare process checks o_READY, o_rdata and o_irq on
//                every falling edge; directed scenarios add literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_bank;

    localparam int N_CH  = 4;
    localparam int CNT_W = 8;
    localparam int PRE_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;
    localparam int PMAX  = (1 << PRE_W) - 1;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b1;
    logic [N_CH-1:0] irq;

    timer_bank_if bus ();

    timer_bank #(
        .N_CH  (N_CH),
        .CNT_W (CNT_W),
        .PRE_W (PRE_W)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus),
        .o_irq   (irq)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------------
    bit          m_en [N_CH];
    bit          m_rld[N_CH];
    bit          m_ie [N_CH];
    int          m_presc[N_CH];
    int          m_pre[N_CH];
    int          m_cnt[N_CH];
    int          m_cmp[N_CH];
    bit          m_match[N_CH];
    bit          m_ovf[N_CH];
    bit          m_resp;
    logic [31:0] m_rdata;

    bit          acc, tick, sm, so;
    int          ch, rg, nc, np;
    logic [31:0] v, d;
    logic [3:0]  s;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] st);
        logic [31:0] m = '0;
        for (int b = 0; b < 4; b++) if (st[b]) m[8*b +: 8] = 8'hFF;
        return (old & ~m) | (wd & m);
    endfunction

    function automatic logic [31:0] m_read(input int c, input int r);
        if (c >= N_CH) return 32'h0;
        case (r)
            0: return {16'h0, 8'(m_presc[c]), 5'b0, m_ie[c], m_rld[c], m_en[c]};
            1: return 32'(m_cnt[c]);
            2: return 32'(m_cmp[c]);
            default: return {30'h0, m_ovf[c], m_match[c]};
        endcase
    endfunction

    function automatic logic [N_CH-1:0] m_irq();
        logic [N_CH-1:0] r = '0;
        for (int c = 0; c < N_CH; c++) r[c] = m_ie[c] && (m_match[c] || m_ovf[c]);
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_resp  = 1'b0;
            m_rdata = '0;
            for (int c = 0; c < N_CH; c++) begin
                m_en[c] = 0; m_rld[c] = 0; m_ie[c] = 0; m_presc[c] = 0; m_pre[c] = 0;
                m_cnt[c] = 0; m_cmp[c] = CMAX; m_match[c] = 0; m_ovf[c] = 0;
            end
        end else begin
            acc = !m_resp && bus.i_VALID;
            ch  = int'(bus.i_addr[7:4]);
            rg  = int'(bus.i_addr[3:2]);
            d   = bus.i_wdata;
            s   = bus.i_strb;
            if (m_resp) begin
                m_resp  = 1'b0;
                m_rdata = '0;
            end else if (acc) begin
                m_resp  = 1'b1;
                m_rdata = bus.i_wren ? 32'h0 : m_read(ch, rg);
            end
            for (int c = 0; c < N_CH; c++) begin
                tick = m_en[c] && (m_pre[c] == m_presc[c]);
                np = m_en[c] ? (tick ? 0 : (m_pre[c] + 1) % (PMAX + 1)) : m_pre[c];
                nc = m_cnt[c];
                sm = 0; so = 0;
                if (tick) begin
                    sm = (m_cnt[c] == m_cmp[c]);
                    so = (m_cnt[c] == CMAX);
                    nc = (sm && m_rld[c]) ? 0 : (m_cnt[c] + 1) % (CMAX + 1);
                end
                if (acc && bus.i_wren && ch == c) begin
                    case (rg)
                        0: begin
                            v = merge(m_read(c, 0), d, s);
                            m_en[c] = v[0]; m_rld[c] = v[1]; m_ie[c] = v[2];
                            m_presc[c] = int'(v[15:8]) & PMAX;
                            np = 0;
                        end
                        1: begin
                            v = merge(32'(m_cnt[c]), d, s);
                            nc = int'(v) & CMAX;
                            np = 0; sm = 0; so = 0;
                        end
                        2: begin
                            v = merge(32'(m_cmp[c]), d, s);
                            m_cmp[c] = int'(v) & CMAX;
                        end
                        default: begin
                            if (s[0] && d[0]) m_match[c] = 0;
                            if (s[0] && d[1]) m_ovf[c] = 0;
                        end
                    endcase
                end
                m_pre[c]   = np;
                m_cnt[c]   = nc;
                m_match[c] = m_match[c] | sm;
                m_ovf[c]   = m_ovf[c] | so;
            end
        end
    end

    // Continuous comparison against the model
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            check("ready_model", bus.o_READY, m_resp);
            check("rdata_model", bus.o_rdata, m_resp ? m_rdata : 32'h0);
            check("irq_model", irq, m_irq());
        end
    end

    // ------------------------------------------------------------------------
    // Bus tasks: called and returning on a falling edge; each takes 2 cycles
    // ------------------------------------------------------------------------
    task automatic xfer(input logic [7:0] a, input bit w, input logic [31:0] wd,
                        input logic [3:0] st, output logic [31:0] rd);
        bus.i_VALID = 1'b1;
        bus.i_addr  = a;
        bus.i_wren  = w;
        bus.i_wdata = wd;
        bus.i_strb  = st;
        @(posedge clk);
        @(negedge clk);
        bus.i_VALID = 1'b0;
        rd = bus.o_rdata;
        check("ready_latency", bus.o_READY, 1'b1);
        @(negedge clk);
        check("ready_one_cycle", bus.o_READY, 1'b0);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] wd, input logic [3:0] st);
        logic [31:0] dummy;
        xfer(a, 1'b1, wd, st, dummy);
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] r);
        xfer(a, 1'b0, 32'h0, 4'h0, r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------------
    logic [31:0] r0, r1;

    initial begin
        bus.i_VALID = 1'b0;
        bus.i_addr  = '0;
        bus.i_wren  = 1'b0;
        bus.i_wdata = '0;
        bus.i_strb  = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Reset values; first request right after release
        check("rst_irq", irq, 0);
        rd(8'h00, r0); check("rst_ctrl0", r0, 32'h0);
        rd(8'h08, r0); check("rst_cmp0", r0, 32'hFF);
        rd(8'h34, r0); check("rst_cnt3", r0, 32'h0);
        rd(8'h1C, r0); check("rst_sts1", r0, 32'h0);

        // ch0 free-running at PRESC=0: enable at E0, reads at E10 and E12
        wr(8'h00, 32'h1, 4'hF);
        repeat (8) @(negedge clk);
        rd(8'h04, r0); check("cnt0_after_9", r0, 32'd9);
        rd(8'h04, r1); check("cnt0_after_11", r1, 32'd11);

        // ch1: COMPARE=5, PRESC=3 with RELOAD/IE/EN: match at 24th cycle
        wr(8'h18, 32'h5, 4'hF);
        wr(8'h10, 32'h307, 4'hF);
        repeat (22) @(negedge clk);
        check("irq1_before_match", irq[1], 1'b0);
        @(negedge clk);
        check("irq1_at_match", irq[1], 1'b1);
        rd(8'h1C, r0); check("sts1_match", r0, 32'h1);
        rd(8'h14, r0); check("cnt1_reloaded", r0, 32'h0);
        wr(8'h1C, 32'h1, 4'hF);
        check("irq1_cleared", irq[1], 1'b0);

        // ch2: COUNT=0xFE, PRESC=3, no reload: 0xFF then wrap with MATCH+OVF
        wr(8'h24, 32'hFE, 4'hF);
        wr(8'h20, 32'h301, 4'hF);
        repeat (4) @(negedge clk);
        rd(8'h24, r0); check("cnt2_ff", r0, 32'hFF);
        rd(8'h2C, r0); check("sts2_before_wrap", r0, 32'h0);
        rd(8'h24, r0); check("cnt2_wrapped", r0, 32'h0);
        rd(8'h2C, r0); check("sts2_match_ovf", r0, 32'h3);

        // ch3: byte strobes
        wr(8'h34, 32'h1234, 4'h2);
        rd(8'h34, r0); check("cnt3_strb_hi_dropped", r0, 32'h0);
        wr(8'h34, 32'h1234, 4'h1);
        rd(8'h34, r0); check("cnt3_strb_lo", r0, 32'h34);
        wr(8'h30, 32'h304, 4'h1);
        rd(8'h30, r0); check("ctrl3_strb_lo", r0, 32'h4);

        // ch3: COMPARE=1 with reload matches on every even edge after enable;
        // W1C accepts land exactly on those edges, so MATCH must persist
        wr(8'h34, 32'h0, 4'hF);
        wr(8'h38, 32'h1, 4'hF);
        wr(8'h30, 32'h7, 4'hF);
        wr(8'h3C, 32'h1, 4'hF);
        wr(8'h3C, 32'h1, 4'hF);
        rd(8'h3C, r0); check("sts3_set_wins", r0, 32'h1);
        check("irq3_set", irq[3], 1'b1);
        wr(8'h30, 32'h0, 4'hF);
        wr(8'h3C, 32'h3, 4'hF);
        check("irq3_cleared", irq[3], 1'b0);

        // Unmapped channel 7
        rd(8'h70, r0); check("unmapped_rd", r0, 32'h0);
        wr(8'h78, 32'h12, 4'hF);
        wr(8'h70, 32'h7, 4'hF);
        rd(8'h38, r0); check("ch3_cmp_intact", r0, 32'h1);
        rd(8'h30, r0); check("ch3_ctrl_intact", r0, 32'h0);
        rd(8'h78, r0); check("unmapped_cmp_rd", r0, 32'h0);

        // Reset in the response cycle of a CTRL write
        bus.i_VALID = 1'b1;
        bus.i_addr  = 8'h10;
        bus.i_wren  = 1'b1;
        bus.i_wdata = 32'h105;
        bus.i_strb  = 4'hF;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_abort_ready", bus.o_READY, 1'b0);
        check("rst_abort_rdata", bus.o_rdata, 32'h0);
        check("rst_abort_irq", irq, 0);
        bus.i_VALID = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rd(8'h10, r0); check("rst_write_lost", r0, 32'h0);
        rd(8'h18, r0); check("rst_cmp1", r0, 32'hFF);
        rd(8'h04, r0); check("rst_cnt0", r0, 32'h0);
        rd(8'h2C, r0); check("rst_sts2", r0, 32'h0);

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
